mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the single processor–memory port among three requesters: commit-stage stores, load-buffer reads and instruction fetch. Arbitration is per cycle and combinational. The block tracks outstanding load tags so that each memory response goes to the requester that issued it. On a branch squash it discards in-flight fetch responses. It sits between IF, the load buffer, ROB commit and the memory model, and its grants drive the hazard unit's memory-stall inputs.

## Interface
- `NUM_TAGS`, 15: number of memory tags, 1..NUM_TAGS; tag 0 means "no response".
- `AGE_LIMIT`, 8: consecutive fetch losses before fetch is promoted (aging builds only).
- `clock` in 1: system clock.
- `reset` in 1: synchronous, active-high. Clock is `clock`.
- `st_req`, `st_addr`, `st_data`, `st_size` in 1/32/64/2: commit store request.
- `st_grant` out 1: store accepted by memory this cycle.
- `lb_req`, `lb_addr`, `lb_size` in 1/32/2: load-buffer read request.
- `lb_grant` out 1: load accepted this cycle.
- `lb_data_valid` out 1 and `lb_data` out 64: load data return.
- `if_req`, `if_addr` in 1/32: instruction fetch request (64-bit line).
- `if_grant` out 1: fetch accepted this cycle.
- `if_data_valid` out 1 and `if_data` out 64: fetch data return.
- `squash` in 1: branch mispredict; discard outstanding fetches.
- `proc2mem_command` out 2: BUS_NONE/BUS_LOAD/BUS_STORE.
- `proc2mem_addr` out 32 and `proc2mem_data` out 64: memory request fields.
- `proc2mem_size` out 2: memory access size.
- `mem2proc_response` in 4: tag assigned to the presented request; 0 = rejected.
- `mem2proc_tag` in 4 and `mem2proc_data` in 64: completing tag and its data.
- `tags_full` out 1: every tag is outstanding.
- `tag_err` out 1: one-cycle pulse when a tag returns that has no valid entry.

## Operation
- Priority without aging: store > load > fetch. At most one request is presented per cycle.
- `*_grant` = selected & (`mem2proc_response` != 0). A rejected request is not granted; the requester holds its request.
- Stores allocate no table entry. Their response tag is ignored.
- Granted loads and fetches write the entry at index `mem2proc_response`: valid=1, owner (OWN_IF/OWN_LB), drop=0.
- When `tags_full`=1, loads and fetches are masked out of arbitration. Stores still arbitrate.
- Return path: `mem2proc_tag`≠0 with a valid entry clears the entry.
  - If drop=0, the data goes to the owner's data output, registered.
  - If drop=1, the data is silently discarded.
- A returning tag with no valid entry is ignored and raises `tag_err` the next cycle.
- `squash` sets drop on every valid OWN_IF entry allocated before this cycle. A fetch granted in the squash cycle is not dropped, because it is the new-path fetch.
- Same-cycle return and allocation of the same tag: the return is processed first, then the allocation writes the entry.

## Timing
- Grants and `proc2mem_*` are combinational, in the same cycle as the request.
- `lb_data_valid`/`if_data_valid` assert exactly 1 cycle after the matching `mem2proc_tag`, for one cycle.
- Reset:
  - table entries are invalid and the aging counter is 0;
  - `lb_data_valid`, `if_data_valid`, `tag_err`, `tags_full` = 0; data outputs = 0;
  - while `reset`=1, all grants = 0 and `proc2mem_command` = BUS_NONE.
- Reset mid-operation: memory responses that arrive after reset find no entry, are dropped and pulse `tag_err`.

## Configuration
- `MEM_ARB_AGING_EN` defined:
  - a counter increments each cycle `if_req`=1 and fetch is not selected;
  - it clears on `if_grant` or when `if_req`=0;
  - at `AGE_LIMIT`, fetch gets top priority, above stores, until granted.
- `MEM_ARB_AGING_EN` undefined: no counter; fixed priority only.

## Structure
- Shared package `mem_arb_pkg`:
  - `mem_owner_t` {OWN_IF, OWN_LB};
  - tag-entry struct {valid, owner, drop};
  - BUS_* command encodings are reused from the system defines.
- Sub-module `mem_tag_table` holds the valid/owner/drop array. It handles allocate, return lookup, squash marking and `tags_full`.
- The arbiter top holds the priority mux, the aging counter and the output registers.

## Test plan
- `st_req`=1 and `lb_req`=1 and `if_req`=1, memory response 3 → only `st_grant`=1, `proc2mem_command`=BUS_STORE, no table entry.
- `lb_req` addr 0x100, response 5; 10 cycles later `mem2proc_tag`=5, data 0xDEAD → `lb_data_valid`=1 with 0xDEAD one cycle later, entry 5 cleared.
- Fetch granted with tag 2; `squash` the next cycle; tag 2 returns → `if_data_valid` stays 0. A fetch granted during the squash cycle with tag 4 returns normally.
- Fill all 15 tags with loads → `tags_full`=1, `lb_grant`=0 while a concurrent store is still granted. Returning tag 7 → the next load is granted.
- `mem2proc_tag`=9 with no entry → `tag_err` pulses once, no data valid.
- Aging build: `if_req` and `lb_req` held for 8 cycles, all lb granted → the 9th cycle grants fetch over load and store.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types for the memory port arbiter and its tag table.
// The BUS_* encodings match the system-wide memory command values.
package mem_arb_pkg;
    localparam int TAG_W = 4;
    typedef enum logic [1:0] {BUS_NONE = 2'h0, BUS_LOAD = 2'h1, BUS_STORE = 2'h2} bus_command_t;
    typedef enum logic [1:0] {BYTE = 2'h0, HALF = 2'h1, WORD = 2'h2, DOUBLE = 2'h3} mem_size_t;
    typedef enum logic {OWN_IF = 1'b0, OWN_LB = 1'b1} mem_owner_t;
    typedef enum logic [1:0] {SEL_NONE, SEL_ST, SEL_LB, SEL_IF} sel_t;
    typedef struct packed {
        logic       valid;
        mem_owner_t owner;
        logic       drop;
    } tag_entry_t;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester, memory and status signals of the shared memory port.
interface mem_port_arbiter_if;
    import mem_arb_pkg::*;
    logic               st_req;
    logic [31:0]        st_addr;
    logic [63:0]        st_data;
    logic [1:0]         st_size;
    logic               st_grant;
    logic               lb_req;
    logic [31:0]        lb_addr;
    logic [1:0]         lb_size;
    logic               lb_grant;
    logic               lb_data_valid;
    logic [63:0]        lb_data;
    logic               if_req;
    logic [31:0]        if_addr;
    logic               if_grant;
    logic               if_data_valid;
    logic [63:0]        if_data;
    logic               squash;
    bus_command_t       proc2mem_command;
    logic [31:0]        proc2mem_addr;
    logic [63:0]        proc2mem_data;
    logic [1:0]         proc2mem_size;
    logic [TAG_W-1:0]   mem2proc_response;
    logic [TAG_W-1:0]   mem2proc_tag;
    logic [63:0]        mem2proc_data;
    logic               tags_full;
    logic               tag_err;

    modport slave (
        input  st_req, st_addr, st_data, st_size, lb_req, lb_addr, lb_size, if_req, if_addr, squash,
               mem2proc_response, mem2proc_tag, mem2proc_data,
        output st_grant, lb_grant, lb_data_valid, lb_data, if_grant, if_data_valid, if_data,
               proc2mem_command, proc2mem_addr, proc2mem_data, proc2mem_size, tags_full, tag_err
    );
    modport master (
        output st_req, st_addr, st_data, st_size, lb_req, lb_addr, lb_size, if_req, if_addr, squash,
               mem2proc_response, mem2proc_tag, mem2proc_data,
        input  st_grant, lb_grant, lb_data_valid, lb_data, if_grant, if_data_valid, if_data,
               proc2mem_command, proc2mem_addr, proc2mem_data, proc2mem_size, tags_full, tag_err
    );
endinterface

// File: rtl/mem_tag_table.sv
// mem_tag_table: outstanding-tag table (valid/owner/drop) with allocate, return lookup and squash marking.
module mem_tag_table
    import mem_arb_pkg::*;
#(
    parameter int NUM_TAGS = 15
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             alloc_en,
    input  logic [TAG_W-1:0] alloc_tag,
    input  mem_owner_t       alloc_owner,
    input  logic [TAG_W-1:0] ret_tag,
    input  logic             squash,
    output logic             ret_deliver,
    output mem_owner_t       ret_owner,
    output logic             ret_miss,
    output logic             tags_full
);
    tag_entry_t entries_q [NUM_TAGS+1];
    tag_entry_t entries_d [NUM_TAGS+1];
    tag_entry_t ret_entry;

    assign ret_entry   = entries_q[ret_tag];
    assign ret_deliver = ret_tag != '0 && ret_entry.valid && !ret_entry.drop;
    assign ret_owner   = ret_entry.owner;
    assign ret_miss    = ret_tag != '0 && !ret_entry.valid;

    // Squash only sees entries already present; the return clears before a same-tag allocation rewrites.
    always_comb begin
        entries_d = entries_q;
        for (int i = 1; i <= NUM_TAGS; i++) begin
            if (squash && entries_q[i].valid && entries_q[i].owner == OWN_IF) entries_d[i].drop = 1'b1;
            if (ret_tag == TAG_W'(i)) entries_d[i] = '0;
            if (alloc_en && alloc_tag == TAG_W'(i)) entries_d[i] = '{valid: 1'b1, owner: alloc_owner, drop: 1'b0};
        end
    end

    always_comb begin
        tags_full = 1'b1;
        for (int i = 1; i <= NUM_TAGS; i++) tags_full = tags_full && entries_q[i].valid;
    end

    always_ff @(posedge clock) begin
        if (reset) entries_q <= '{default: '0};
        else entries_q <= entries_d;
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port among store, load and fetch requesters with tag-routed returns.
// Define MEM_ARB_AGING_EN to promote a starved fetch after AGE_LIMIT consecutive losses.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_TAGS  = 15,
    parameter int AGE_LIMIT = 8
) (
    input logic               clock,
    input logic               reset,
    mem_port_arbiter_if.slave bus
);
    sel_t        sel;
    logic        ld_ok, fe_ok, fe_aged, accept;
    logic        ret_deliver, ret_miss;
    mem_owner_t  ret_owner;
    logic        lb_data_valid_q, lb_data_valid_d, if_data_valid_q, if_data_valid_d;
    logic        tag_err_q, tag_err_d;
    logic [63:0] lb_data_q, lb_data_d, if_data_q, if_data_d;

    assign ld_ok  = bus.lb_req && !bus.tags_full;
    assign fe_ok  = bus.if_req && !bus.tags_full;
    assign accept = bus.mem2proc_response != '0;

`ifdef MEM_ARB_AGING_EN
    localparam int AGE_W = $clog2(AGE_LIMIT + 1);
    logic [AGE_W-1:0] age_q, age_d;
    assign fe_aged = fe_ok && age_q == AGE_W'(AGE_LIMIT);
    always_comb age_d = (!bus.if_req || bus.if_grant) ? '0 :
                        (sel != SEL_IF && age_q != AGE_W'(AGE_LIMIT)) ? age_q + 1'b1 : age_q;
    always_ff @(posedge clock) age_q <= reset ? '0 : age_d;
`else
    logic age_unused;
    assign age_unused = AGE_LIMIT > 0;
    assign fe_aged    = 1'b0;
`endif

    always_comb sel = reset ? SEL_NONE : fe_aged ? SEL_IF : bus.st_req ? SEL_ST :
                      ld_ok ? SEL_LB : fe_ok ? SEL_IF : SEL_NONE;

    assign bus.st_grant = sel == SEL_ST && accept;
    assign bus.lb_grant = sel == SEL_LB && accept;
    assign bus.if_grant = sel == SEL_IF && accept;

    always_comb begin
        bus.proc2mem_command = sel == SEL_ST ? BUS_STORE : sel == SEL_NONE ? BUS_NONE : BUS_LOAD;
        bus.proc2mem_addr    = sel == SEL_ST ? bus.st_addr : sel == SEL_LB ? bus.lb_addr :
                               sel == SEL_IF ? bus.if_addr : '0;
        bus.proc2mem_data    = sel == SEL_ST ? bus.st_data : '0;
        bus.proc2mem_size    = sel == SEL_ST ? bus.st_size : sel == SEL_LB ? bus.lb_size :
                               sel == SEL_IF ? DOUBLE : BYTE;
    end

    mem_tag_table #(.NUM_TAGS(NUM_TAGS)) u_tags (
        .clock,
        .reset,
        .alloc_en   (bus.lb_grant || bus.if_grant),
        .alloc_tag  (bus.mem2proc_response),
        .alloc_owner(bus.lb_grant ? OWN_LB : OWN_IF),
        .ret_tag    (bus.mem2proc_tag),
        .squash     (bus.squash),
        .ret_deliver,
        .ret_owner,
        .ret_miss,
        .tags_full  (bus.tags_full)
    );

    always_comb begin
        lb_data_valid_d = ret_deliver && ret_owner == OWN_LB;
        if_data_valid_d = ret_deliver && ret_owner == OWN_IF;
        lb_data_d       = lb_data_valid_d ? bus.mem2proc_data : lb_data_q;
        if_data_d       = if_data_valid_d ? bus.mem2proc_data : if_data_q;
        tag_err_d       = ret_miss;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            lb_data_valid_q <= 1'b0;
            if_data_valid_q <= 1'b0;
            lb_data_q       <= '0;
            if_data_q       <= '0;
            tag_err_q       <= 1'b0;
        end else begin
            lb_data_valid_q <= lb_data_valid_d;
            if_data_valid_q <= if_data_valid_d;
            lb_data_q       <= lb_data_d;
            if_data_q       <= if_data_d;
            tag_err_q       <= tag_err_d;
        end
    end

    assign bus.lb_data_valid = lb_data_valid_q;
    assign bus.if_data_valid = if_data_valid_q;
    assign bus.lb_data       = lb_data_q;
    assign bus.if_data       = if_data_q;
    assign bus.tag_err       = tag_err_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: vector table, directed corner sequences and random traffic against a tag-map model.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;
    localparam int NUM_TAGS  = 15;
    localparam int AGE_LIMIT = 8;

    logic clock = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    mem_port_arbiter_if bus();
    mem_port_arbiter #(.NUM_TAGS(NUM_TAGS), .AGE_LIMIT(AGE_LIMIT)) dut (.clock(clock), .reset(reset), .bus(bus));

    always #5 clock = ~clock;

    // Model: outstanding tags map to 'L' (load), 'F' (live fetch) or 'X' (squashed fetch).
    byte         kind_m [int];
    int          age_cnt = 0;
    logic        e_lbv = 1'b0, e_ifv = 1'b0, e_err = 1'b0;
    logic [63:0] e_lbd = '0, e_ifd = '0;

    typedef struct {
        int           st, lb, fi, resp;
        int           g_st, g_lb, g_if;
        bus_command_t cmd;
    } vec_t;
    vec_t vecs [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input int st, lb, fi, sq, resp, rtag, input logic [63:0] rdata);
        bus.st_req            = st != 0;
        bus.lb_req            = lb != 0;
        bus.if_req            = fi != 0;
        bus.squash            = sq != 0;
        bus.mem2proc_response = 4'(resp);
        bus.mem2proc_tag      = 4'(rtag);
        bus.mem2proc_data     = rdata;
    endtask

    // Called right after a negedge with inputs driven; checks this cycle and the registered results.
    task automatic cycle();
        int   sel, t;
        logic full, acc, aged;
        #1;
        full = kind_m.num() == NUM_TAGS;
        acc  = bus.mem2proc_response != 0;
        aged = 1'b0;
`ifdef MEM_ARB_AGING_EN
        aged = bus.if_req && !full && age_cnt >= AGE_LIMIT;
`endif
        if (reset) sel = 0;
        else if (aged) sel = 3;
        else if (bus.st_req) sel = 1;
        else if (bus.lb_req && !full) sel = 2;
        else if (bus.if_req && !full) sel = 3;
        else sel = 0;
        chk("tags_full", bus.tags_full, full);
        chk("st_grant", bus.st_grant, sel == 1 && acc);
        chk("lb_grant", bus.lb_grant, sel == 2 && acc);
        chk("if_grant", bus.if_grant, sel == 3 && acc);
        chk("command", bus.proc2mem_command, sel == 0 ? BUS_NONE : sel == 1 ? BUS_STORE : BUS_LOAD);
        if (sel != 0) begin
            chk("addr", bus.proc2mem_addr, sel == 1 ? bus.st_addr : sel == 2 ? bus.lb_addr : bus.if_addr);
            chk("size", bus.proc2mem_size, sel == 1 ? bus.st_size : sel == 2 ? bus.lb_size : 2'd3);
        end
        if (sel == 1) chk("st_data", bus.proc2mem_data, bus.st_data);
        if (reset) begin
            kind_m.delete();
            age_cnt = 0;
            {e_lbv, e_ifv, e_err} = '0;
            e_lbd = '0;
            e_ifd = '0;
        end else begin
            {e_lbv, e_ifv, e_err} = '0;
            t = int'(bus.mem2proc_tag);
            if (t != 0) begin
                if (!kind_m.exists(t)) e_err = 1'b1;
                else begin
                    if (kind_m[t] == "L") begin e_lbv = 1'b1; e_lbd = bus.mem2proc_data; end
                    if (kind_m[t] == "F") begin e_ifv = 1'b1; e_ifd = bus.mem2proc_data; end
                    kind_m.delete(t);
                end
            end
            if (bus.squash) foreach (kind_m[k]) if (kind_m[k] == "F") kind_m[k] = "X";
            if (acc && sel == 2) kind_m[int'(bus.mem2proc_response)] = "L";
            if (acc && sel == 3) kind_m[int'(bus.mem2proc_response)] = "F";
            if (!bus.if_req || (acc && sel == 3)) age_cnt = 0;
            else if (sel != 3) age_cnt++;
        end
        @(negedge clock);
        chk("lb_data_valid", bus.lb_data_valid, e_lbv);
        chk("lb_data", bus.lb_data, e_lbd);
        chk("if_data_valid", bus.if_data_valid, e_ifv);
        chk("if_data", bus.if_data, e_ifd);
        chk("tag_err", bus.tag_err, e_err);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        cycle();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        bus.st_addr = 32'h1000; bus.st_data = 64'h5555_AAAA_1234_5678; bus.st_size = 2'd2;
        bus.lb_addr = 32'h100;  bus.lb_size = 2'd3; bus.if_addr = 32'h2000;
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clock);

        // Requests held during reset must not be granted
        drive(1, 1, 1, 0, 3, 0, 0);
        cycle();
        cycle();
        reset = 1'b0;

        vecs = '{
            '{1, 1, 1, 3, 1, 0, 0, BUS_STORE},
            '{0, 1, 1, 5, 0, 1, 0, BUS_LOAD},
            '{0, 0, 1, 2, 0, 0, 1, BUS_LOAD},
            '{1, 0, 0, 0, 0, 0, 0, BUS_STORE},
            '{0, 1, 0, 0, 0, 0, 0, BUS_LOAD},
            '{0, 0, 0, 6, 0, 0, 0, BUS_NONE},
            '{0, 1, 1, 0, 0, 0, 0, BUS_LOAD},
            '{1, 1, 0, 7, 1, 0, 0, BUS_STORE}
        };
        foreach (vecs[i]) begin
            drive(vecs[i].st, vecs[i].lb, vecs[i].fi, 0, vecs[i].resp, 0, 0);
            #1;
            chk("vec_st_grant", bus.st_grant, vecs[i].g_st);
            chk("vec_lb_grant", bus.lb_grant, vecs[i].g_lb);
            chk("vec_if_grant", bus.if_grant, vecs[i].g_if);
            chk("vec_command", bus.proc2mem_command, vecs[i].cmd);
            cycle();
        end

        // Store response tag 3 created no entry
        drive(0, 0, 0, 0, 0, 3, 64'h33);
        cycle();
        chk("store_no_entry", bus.tag_err, 1);

        // Tag 5 was outstanding before reset; after reset its return is an error
        do_reset();
        drive(0, 0, 0, 0, 0, 5, 64'h55);
        cycle();
        chk("post_reset_err", bus.tag_err, 1);
        chk("post_reset_lbv", bus.lb_data_valid, 0);

        // Load round trip
        drive(0, 1, 0, 0, 5, 0, 0);
        #1 chk("ld_addr", bus.proc2mem_addr, 32'h100);
        cycle();
        repeat (10) begin drive(0, 0, 0, 0, 0, 0, 0); cycle(); end
        drive(0, 0, 0, 0, 0, 5, 64'hDEAD);
        cycle();
        chk("ld_ret_valid", bus.lb_data_valid, 1);
        chk("ld_ret_data", bus.lb_data, 64'hDEAD);
        drive(0, 0, 0, 0, 0, 0, 0);
        cycle();
        chk("ld_ret_pulse", bus.lb_data_valid, 0);
        drive(0, 0, 0, 0, 0, 5, 0);
        cycle();
        chk("ld_entry_cleared", bus.tag_err, 1);

        // Squash drops the old fetch but keeps the one granted in the squash cycle
        drive(0, 0, 1, 0, 2, 0, 0);
        cycle();
        drive(0, 0, 1, 1, 4, 0, 0);
        #1 chk("squash_cycle_grant", bus.if_grant, 1);
        cycle();
        drive(0, 0, 0, 0, 0, 0, 0);
        cycle();
        drive(0, 0, 0, 0, 0, 2, 64'hBAD);
        cycle();
        chk("squashed_fetch", bus.if_data_valid, 0);
        chk("squashed_no_err", bus.tag_err, 0);
        drive(0, 0, 0, 0, 0, 4, 64'hF00D);
        cycle();
        chk("new_path_valid", bus.if_data_valid, 1);
        chk("new_path_data", bus.if_data, 64'hF00D);

        // Fill every tag with loads
        do_reset();
        for (int t = 1; t <= NUM_TAGS; t++) begin drive(0, 1, 0, 0, t, 0, 0); cycle(); end
        drive(1, 1, 1, 0, 3, 0, 0);
        #1;
        chk("full_flag", bus.tags_full, 1);
        chk("full_lb_masked", bus.lb_grant, 0);
        chk("full_if_masked", bus.if_grant, 0);
        chk("full_st_grant", bus.st_grant, 1);
        cycle();
        drive(0, 1, 0, 0, 7, 7, 64'h77);
        #1 chk("full_lb_only", bus.lb_grant, 0);
        cycle();
        drive(0, 1, 0, 0, 7, 0, 0);
        #1;
        chk("freed_not_full", bus.tags_full, 0);
        chk("freed_lb_grant", bus.lb_grant, 1);
        cycle();

        // Unknown tag
        do_reset();
        drive(0, 0, 0, 0, 0, 9, 64'h99);
        cycle();
        chk("tag_err_pulse", bus.tag_err, 1);
        chk("tag_err_no_lbv", bus.lb_data_valid, 0);
        chk("tag_err_no_ifv", bus.if_data_valid, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        cycle();
        chk("tag_err_once", bus.tag_err, 0);

        // Fetch starved by loads for AGE_LIMIT cycles
        do_reset();
        for (int c = 0; c < AGE_LIMIT; c++) begin
            drive(0, 1, 1, 0, c + 1, 0, 0);
            #1 chk("starve_lb_grant", bus.lb_grant, 1);
            cycle();
        end
        drive(1, 1, 1, 0, 9, 0, 0);
        #1;
`ifdef MEM_ARB_AGING_EN
        chk("aged_if_grant", bus.if_grant, 1);
        chk("aged_st_blocked", bus.st_grant, 0);
`else
        chk("fixed_st_grant", bus.st_grant, 1);
        chk("fixed_if_lost", bus.if_grant, 0);
`endif
        cycle();

        // Random traffic
        do_reset();
        for (int n = 0; n < 2000; n++) begin
            int keys[$];
            int freeq[$];
            int rtag, resp, r;
            foreach (kind_m[k]) keys.push_back(k);
            for (int t = 1; t <= NUM_TAGS; t++) if (!kind_m.exists(t)) freeq.push_back(t);
            r = $urandom_range(0, 9);
            rtag = 0;
            if (r < 5 && keys.size() > 0) rtag = keys[$urandom_range(0, keys.size() - 1)];
            else if (r == 5) rtag = $urandom_range(1, NUM_TAGS);
            r = $urandom_range(0, 9);
            if (r < 2) resp = 0;
            else if (r == 2 && rtag != 0) resp = rtag;
            else if (freeq.size() > 0) resp = freeq[$urandom_range(0, freeq.size() - 1)];
            else resp = $urandom_range(1, NUM_TAGS);
            reset = $urandom_range(0, 299) == 0;
            bus.st_addr = $urandom; bus.st_data = {$urandom, $urandom}; bus.st_size = 2'($urandom_range(0, 3));
            bus.lb_addr = $urandom; bus.lb_size = 2'($urandom_range(0, 3)); bus.if_addr = $urandom;
            drive($urandom_range(0, 2) == 0, $urandom_range(0, 1), $urandom_range(0, 1),
                  $urandom_range(0, 9) == 0, resp, rtag, {$urandom, $urandom});
            cycle();
        end
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
